ram_64x8_ctrl: RTL and testbench

- Host-side initiator for the 64x8 latch-based RAM.
- Accepts single-word read/write requests on a valid/ready interface.
- Sequences the RAM pins (ram_a, ram_cs, ram_oe, ram_we, ram_di) through fixed setup/strobe/hold phases, captures ram_dout on reads, and returns a one-cycle completion pulse.
- Sits between any bus master and the RAM array. It is the only driver of the RAM control pins.

---
 rtl/ram_64x8_ctrl.sv | 155 +++++++++++++++
 tb/tb_ram_64x8_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_64x8_ctrl.sv
// Host-side sequencer for the 64x8 latch RAM: one valid/ready request becomes a
// SETUP/STROBE/HOLD pin sequence. Define RAM_CTRL_CLEAR_EN to zero the array after reset.
module ram_64x8_ctrl #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       init_done,
    output logic [5:0] ram_a,
    output logic       ram_cs,
    output logic       ram_oe,
    output logic       ram_we,
    output logic [7:0] ram_di,
    input  logic [7:0] ram_dout
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CLEAR  = 3'd4
    } state_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       op_we_q;

`ifdef RAM_CTRL_CLEAR_EN
    logic       init_done_q;
    localparam state_t RST_STATE = ST_CLEAR;
    assign init_done = init_done_q;
`else
    localparam state_t RST_STATE = ST_IDLE;
    assign init_done = 1'b1;
`endif

    // Sequencer FSM; every output pin is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_STATE;
            cnt_q     <= 4'd0;
            op_we_q   <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            ram_a     <= 6'd0;
            ram_di    <= 8'h00;
            ram_cs    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_we    <= 1'b0;
`ifdef RAM_CTRL_CLEAR_EN
            init_done_q <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_we_q   <= req_we;
                        ram_a     <= req_addr;
                        ram_di    <= req_wdata;
                        cnt_q     <= SETUP_LOAD;
                        ram_cs    <= 1'b1;
                        req_ready <= 1'b0;
                        state_q   <= ST_SETUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == 4'd0) begin
                        cnt_q   <= STROBE_LOAD;
                        ram_we  <= op_we_q;
                        ram_oe  <= ~op_we_q;
                        state_q <= ST_STROBE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == 4'd0) begin
                        ram_we  <= 1'b0;
                        ram_oe  <= 1'b0;
                        state_q <= ST_HOLD;
                        if (!op_we_q) begin
                            rsp_rdata <= ram_dout;
                        end else begin
                            rsp_rdata <= rsp_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HOLD: begin
`ifdef RAM_CTRL_CLEAR_EN
                    // Before init_done the HOLD either chains into the next clear write or finishes the sweep.
                    if (!init_done_q) begin
                        if (ram_a == 6'd63) begin
                            init_done_q <= 1'b1;
                            ram_cs      <= 1'b0;
                            req_ready   <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            ram_a   <= ram_a + 6'd1;
                            cnt_q   <= SETUP_LOAD;
                            state_q <= ST_SETUP;
                        end
                    end else begin
                        ram_cs    <= 1'b0;
                        rsp_valid <= 1'b1;
                        req_ready <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
`else
                    ram_cs    <= 1'b0;
                    rsp_valid <= 1'b1;
                    req_ready <= 1'b1;
                    state_q   <= ST_IDLE;
`endif
                end
`ifdef RAM_CTRL_CLEAR_EN
                ST_CLEAR: begin
                    op_we_q <= 1'b1;
                    ram_a   <= 6'd0;
                    ram_di  <= 8'h00;
                    ram_cs  <= 1'b1;
                    cnt_q   <= SETUP_LOAD;
                    state_q <= ST_SETUP;
                end
`endif
                default: begin
                    ram_cs    <= 1'b0;
                    ram_oe    <= 1'b0;
                    ram_we    <= 1'b0;
                    req_ready <= 1'b0;
                    cnt_q     <= 4'd0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_64x8_ctrl.sv
// Scoreboard bench for ram_64x8_ctrl: instance 0 uses default timing, instance 1 SETUP_CYC=2/STROBE_CYC=3.
module tb_ram_64x8_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_we    [2];
    logic [5:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       init_done [2];
    logic [5:0] ram_a     [2];
    logic       ram_cs    [2];
    logic       ram_oe    [2];
    logic       ram_we    [2];
    logic [7:0] ram_di    [2];
    logic [7:0] ram_dout  [2];

    logic [7:0] mem [2][64];
    logic [7:0] last_rd [2];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    int vectors    = 0;
    int miscompares = 0;

    ram_64x8_ctrl u0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .init_done(init_done[0]),
        .ram_a(ram_a[0]), .ram_cs(ram_cs[0]), .ram_oe(ram_oe[0]), .ram_we(ram_we[0]),
        .ram_di(ram_di[0]), .ram_dout(ram_dout[0])
    );

    ram_64x8_ctrl #(.SETUP_CYC(2), .STROBE_CYC(3)) u1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .init_done(init_done[1]),
        .ram_a(ram_a[1]), .ram_cs(ram_cs[1]), .ram_oe(ram_oe[1]), .ram_we(ram_we[1]),
        .ram_di(ram_di[1]), .ram_dout(ram_dout[1])
    );

    // RAM models: data only appears while oe is high, writes land while we is high
    assign ram_dout[0] = ram_oe[0] ? mem[0][ram_a[0]] : 8'h00;
    assign ram_dout[1] = ram_oe[1] ? mem[1][ram_a[1]] : 8'h00;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_we[i]) mem[i][ram_a[i]] <= ram_di[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        if (!rst[0]) begin
            chk("oe_we_excl0", {31'd0, ram_oe[0] & ram_we[0]}, 32'd0);
            if (rsp_valid[0]) begin
                if (exp_q0.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rsp0_unexpected: got rsp_valid=1, expected no response");
                end else begin
                    chk("rsp0_rdata", {24'd0, rsp_rdata[0]}, {24'd0, exp_q0.pop_front()});
                end
            end
        end
        if (!rst[1]) begin
            chk("oe_we_excl1", {31'd0, ram_oe[1] & ram_we[1]}, 32'd0);
            if (rsp_valid[1]) begin
                if (exp_q1.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rsp1_unexpected: got rsp_valid=1, expected no response");
                end else begin
                    chk("rsp1_rdata", {24'd0, rsp_rdata[1]}, {24'd0, exp_q1.pop_front()});
                end
            end
        end
    end

    // Wait for ready, present the request, return just after the accepting edge.
    task automatic accept(input int i, input logic we, input logic [5:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input bit push, output bit saw_rsp);
        int guard = 0;
        @(negedge clk);
        while (!req_ready[i] && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) begin
            vectors++; miscompares++;
            $display("FAIL accept%0d_timeout: req_ready stayed 0, expected 1", i);
        end
        saw_rsp      = rsp_valid[i];
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = d;
        @(posedge clk);
        if (push) begin
            if (!we) last_rd[i] = exp_rd;
            if (i == 0) exp_q0.push_back(last_rd[i]);
            else        exp_q1.push_back(last_rd[i]);
        end
    endtask

    task automatic check_phases(input int i, input logic we, input logic [5:0] a, input logic [7:0] d);
        int s = (i == 0) ? 1 : 2;
        int t = (i == 0) ? 1 : 3;
        for (int c = 1; c <= s + t + 1; c++) begin
            logic strobe;
            @(negedge clk);
            strobe = (c > s) && (c <= s + t);
            chk($sformatf("i%0d_c%0d_cs", i, c), {31'd0, ram_cs[i]}, 32'd1);
            chk($sformatf("i%0d_c%0d_oe", i, c), {31'd0, ram_oe[i]}, {31'd0, strobe & ~we});
            chk($sformatf("i%0d_c%0d_we", i, c), {31'd0, ram_we[i]}, {31'd0, strobe & we});
            chk($sformatf("i%0d_c%0d_addr", i, c), {26'd0, ram_a[i]}, {26'd0, a});
            if (we) chk($sformatf("i%0d_c%0d_di", i, c), {24'd0, ram_di[i]}, {24'd0, d});
            chk($sformatf("i%0d_c%0d_ready", i, c), {31'd0, req_ready[i]}, 32'd0);
            chk($sformatf("i%0d_c%0d_rspv", i, c), {31'd0, rsp_valid[i]}, 32'd0);
        end
    endtask

    task automatic check_rsp_cycle(input int i);
        @(negedge clk);
        chk($sformatf("i%0d_rsp_pulse", i), {31'd0, rsp_valid[i]}, 32'd1);
        chk($sformatf("i%0d_rsp_ready", i), {31'd0, req_ready[i]}, 32'd1);
        chk($sformatf("i%0d_rsp_cs", i), {31'd0, ram_cs[i]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    initial begin
        bit saw;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = 6'd0; req_wdata[i] = 8'h00; last_rd[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d_ready", i), {31'd0, req_ready[i]}, 32'd0);
            chk($sformatf("rst%0d_rspv", i), {31'd0, rsp_valid[i]}, 32'd0);
            chk($sformatf("rst%0d_rdata", i), {24'd0, rsp_rdata[i]}, 32'd0);
            chk($sformatf("rst%0d_addr", i), {26'd0, ram_a[i]}, 32'd0);
            chk($sformatf("rst%0d_di", i), {24'd0, ram_di[i]}, 32'd0);
            chk($sformatf("rst%0d_pins", i), {29'd0, ram_cs[i], ram_oe[i], ram_we[i]}, 32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

`ifdef RAM_CTRL_CLEAR_EN
        begin
            int low_cycles = 0;
            @(negedge clk);
            while (!init_done[0] && low_cycles < 300) begin
                chk("clear_ready_low", {31'd0, req_ready[0]}, 32'd0);
                low_cycles++;
                @(negedge clk);
            end
            chk("clear_duration", low_cycles, 32'd192);
            accept(0, 1'b0, 6'h3F, 8'h00, 8'h00, 1'b1, saw);
            #1 req_valid[0] = 1'b0;
            check_phases(0, 1'b0, 6'h3F, 8'h00);
            check_rsp_cycle(0);
        end
`endif

        // Single write then read-back at default timing
        accept(0, 1'b1, 6'h2A, 8'h5A, 8'h00, 1'b1, saw);
        #1 req_valid[0] = 1'b0;
        check_phases(0, 1'b1, 6'h2A, 8'h5A);
        check_rsp_cycle(0);

        accept(0, 1'b0, 6'h2A, 8'h00, 8'h5A, 1'b1, saw);
        #1 req_valid[0] = 1'b0;
        check_phases(0, 1'b0, 6'h2A, 8'h00);
        check_rsp_cycle(0);

        // Back-to-back: read held valid during the write, accepted on its completion cycle
        accept(0, 1'b1, 6'h00, 8'h11, 8'h00, 1'b1, saw);
        #1 begin req_we[0] = 1'b0; req_addr[0] = 6'h00; req_wdata[0] = 8'hEE; end
        check_phases(0, 1'b1, 6'h00, 8'h11);
        accept(0, 1'b0, 6'h00, 8'hEE, 8'h11, 1'b1, saw);
        chk("b2b_accept_in_rsp_cycle", {31'd0, saw}, 32'd1);
        #1 req_valid[0] = 1'b0;
        check_phases(0, 1'b0, 6'h00, 8'h00);
        check_rsp_cycle(0);

        // Stretched timing instance: preload 0x3F then read it back
        accept(1, 1'b1, 6'h3F, 8'hC3, 8'h00, 1'b1, saw);
        #1 req_valid[1] = 1'b0;
        check_phases(1, 1'b1, 6'h3F, 8'hC3);
        check_rsp_cycle(1);
        accept(1, 1'b0, 6'h3F, 8'h00, 8'hC3, 1'b1, saw);
        #1 req_valid[1] = 1'b0;
        check_phases(1, 1'b0, 6'h3F, 8'h00);
        check_rsp_cycle(1);

`ifndef RAM_CTRL_CLEAR_EN
        // Reset during the write strobe: pins drop, no response, ready returns
        accept(0, 1'b1, 6'h05, 8'h77, 8'h00, 1'b0, saw);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_strobe_we", {31'd0, ram_we[0]}, 32'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("abort_pins", {29'd0, ram_cs[0], ram_oe[0], ram_we[0]}, 32'd0);
        chk("abort_rspv", {31'd0, rsp_valid[0]}, 32'd0);
        chk("abort_rdata_cleared", {24'd0, rsp_rdata[0]}, 32'd0);
        rst[0] = 1'b0;
        last_rd[0] = 8'h00;
        @(negedge clk);
        chk("abort_ready_back", {31'd0, req_ready[0]}, 32'd1);
        repeat (4) @(negedge clk);
        accept(0, 1'b0, 6'h2A, 8'h00, 8'h5A, 1'b1, saw);
        #1 req_valid[0] = 1'b0;
        check_phases(0, 1'b0, 6'h2A, 8'h00);
        check_rsp_cycle(0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard0_drained", exp_q0.size(), 32'd0);
        chk("scoreboard1_drained", exp_q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
